// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with an aligned 64-bit data-memory port
// Turns execute-stage results into doubleword requests and returns extended load data.
module mem_access_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_mem_access,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic                  o_stall_mem,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [7:0]            o_dmem_wstrb,
  input  logic                  i_dmem_ready,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_misaligned,
  output logic [3:0]            o_cause
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic [7:0]            r_dmem_wstrb;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [2:0]            r_off;

  logic                  w_aligned;
  logic                  w_start;
  logic [7:0]            w_mask;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_ext;

  always_comb begin
    w_aligned = 1'b1;
    w_mask    = 8'hFF;
    case (i_func3[1:0])
      2'b00: begin w_aligned = 1'b1;                w_mask = 8'h01; end
      2'b01: begin w_aligned = ~i_addr[0];          w_mask = 8'h03; end
      2'b10: begin w_aligned = (i_addr[1:0] == 2'b00); w_mask = 8'h0F; end
      default: begin w_aligned = (i_addr[2:0] == 3'b000); w_mask = 8'hFF; end
    endcase
  end

  assign w_start      = (r_state == IDLE) & i_mem_access & w_aligned;
  assign o_misaligned = (r_state == IDLE) & i_mem_access & ~w_aligned;
  assign o_cause      = o_misaligned ? (i_mem_we ? 4'd6 : 4'd4) : 4'd0;
  // Stall from the first cycle the access is visible so its operands stay put.
  assign o_stall_mem  = i_mem_access & w_aligned & (r_state != DONE);

  assign w_shifted = i_dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      2'b00: w_ext = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                : {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      2'b01: w_ext = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                : {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      2'b10: w_ext = r_unsigned ? {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]}
                                : {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = REQ;
      REQ:  if (i_dmem_ready) w_next = r_dmem_we ? DONE : RESP;
      RESP: if (i_dmem_rvalid) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wstrb <= 8'h00;
      r_load_data  <= '0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_off        <= 3'b000;
    end else begin
      if (w_start) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= i_mem_we;
        r_dmem_addr  <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
        r_dmem_wdata <= i_write_data << {i_addr[2:0], 3'b000};
        r_dmem_wstrb <= w_mask << i_addr[2:0];
        r_size       <= i_func3[1:0];
        r_unsigned   <= i_func3[2];
        r_off        <= i_addr[2:0];
      end
      if ((r_state == REQ) && i_dmem_ready) r_dmem_req <= 1'b0;
      if ((r_state == RESP) && i_dmem_rvalid) r_load_data <= w_ext;
    end
  end

  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_dmem_wstrb = r_dmem_wstrb;
  assign o_load_data  = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Directed scenarios plus randomized accesses checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_arst, i_mem_access, i_mem_we;
  logic [2:0]  i_func3;
  logic [63:0] i_addr, i_write_data;
  logic        o_stall_mem, o_dmem_req, o_dmem_we;
  logic [63:0] o_dmem_addr, o_dmem_wdata;
  logic [7:0]  o_dmem_wstrb;
  logic        i_dmem_ready, i_dmem_rvalid;
  logic [63:0] i_dmem_rdata, o_load_data;
  logic        o_misaligned;
  logic [3:0]  o_cause;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_load;
  int          ob_stall;
  bit          ob_req_seen, ob_stable, ob_timeout, ob_resp_seen, ob_mis, ob_req_after;
  logic [3:0]  ob_cause;
  logic [63:0] ob_addr, ob_wdata, ob_load;
  logic [7:0]  ob_wstrb;
  logic        ob_we;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .i_clk(clk), .i_arst(i_arst), .i_mem_access(i_mem_access), .i_mem_we(i_mem_we),
    .i_func3(i_func3), .i_addr(i_addr), .i_write_data(i_write_data),
    .o_stall_mem(o_stall_mem), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_load_data(o_load_data), .o_misaligned(o_misaligned), .o_cause(o_cause)
  );

  function automatic int nbytes(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_aligned(logic [63:0] a, logic [2:0] f3);
    return (a % nbytes(f3)) == 0;
  endfunction

  function automatic logic [7:0] m_wstrb(logic [63:0] a, logic [2:0] f3);
    logic [7:0] s = 8'h00;
    int off = int'(a % 8);
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + nbytes(f3)) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(logic [63:0] a, logic [63:0] wd);
    logic [63:0] r = '0;
    int off = int'(a % 8);
    for (int b = 0; b < 8; b++)
      if (b >= off) r[8*b +: 8] = wd[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] a, logic [2:0] f3, logic [63:0] rd);
    logic [63:0] v = '0;
    logic [63:0] byte_v;
    int off = int'(a % 8);
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) begin
      byte_v = {56'd0, rd[8*(off+i) +: 8]};
      v = v | (byte_v << (8*i));
    end
    if (!f3[2] && n < 8 && rd[8*(off+n)-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  // Drives one pipeline access and records what the DUT did; tests judge the record.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] wd, input logic [63:0] rd,
                            input int rdy_dly, input int rv_dly, input bit noise);
    int rc, vc, cyc;
    ob_stall = 0; ob_req_seen = 0; ob_stable = 1; ob_timeout = 0; ob_resp_seen = 0;
    rc = 0; vc = 0;
    i_mem_access = 1'b1; i_mem_we = we; i_func3 = f3; i_addr = a; i_write_data = wd;
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
    #1;
    ob_mis = o_misaligned; ob_cause = o_cause;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (!o_stall_mem) break;
      ob_stall++;
      if (o_dmem_req) begin
        if (!ob_req_seen) begin
          ob_req_seen = 1; ob_addr = o_dmem_addr; ob_wdata = o_dmem_wdata;
          ob_wstrb = o_dmem_wstrb; ob_we = o_dmem_we;
        end else if (o_dmem_addr !== ob_addr || o_dmem_wdata !== ob_wdata ||
                     o_dmem_wstrb !== ob_wstrb || o_dmem_we !== ob_we) begin
          ob_stable = 0;
        end
        if (rc >= rdy_dly) i_dmem_ready = 1'b1;
        else rc++;
        if (noise) begin
          i_dmem_rvalid = 1'($urandom_range(0, 1));
          i_dmem_rdata = {$urandom, $urandom};
        end
      end else if (ob_req_seen) begin
        ob_resp_seen = 1;
        if (vc >= rv_dly) begin
          i_dmem_rvalid = 1'b1; i_dmem_rdata = rd;
        end else begin
          vc++;
          if (noise) i_dmem_rdata = {$urandom, $urandom};
        end
      end
      @(negedge clk);
      i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
      #1;
    end
    if (cyc >= 200) ob_timeout = 1;
    ob_load = o_load_data;
    i_mem_access = 1'b0; i_mem_we = 1'b0; i_func3 = 3'd0; i_addr = '0; i_write_data = '0;
    @(negedge clk);
    #1;
    ob_req_after = o_dmem_req;
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    repeat (2) @(negedge clk);
    i_arst = 1'b0;
    #1;
    checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_dmem_req); end
    checks++; if (o_dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", o_dmem_we); end
    checks++; if (o_dmem_addr !== 64'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", o_dmem_addr); end
    checks++; if (o_dmem_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", o_dmem_wdata); end
    checks++; if (o_dmem_wstrb !== 8'd0) begin errors++; $display("FAIL reset_wstrb: got %h expected 0", o_dmem_wstrb); end
    checks++; if (o_load_data !== 64'd0) begin errors++; $display("FAIL reset_load: got %h expected 0", o_load_data); end
    checks++; if (o_stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall_mem); end
    checks++; if (o_misaligned !== 1'b0 || o_cause !== 4'd0) begin errors++; $display("FAIL reset_exc: got %b/%0d expected 0/0", o_misaligned, o_cause); end
    // Abandon a load while its request is outstanding.
    @(negedge clk);
    i_mem_access = 1'b1; i_mem_we = 1'b0; i_func3 = 3'b011; i_addr = 64'h3000;
    @(negedge clk); #1;
    checks++; if (o_dmem_req !== 1'b1) begin errors++; $display("FAIL midreq_req: got %b expected 1", o_dmem_req); end
    i_arst = 1'b1; i_mem_access = 1'b0;
    @(negedge clk); #1;
    checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL midreq_clear: got %b expected 0", o_dmem_req); end
    checks++; if (o_stall_mem !== 1'b0) begin errors++; $display("FAIL midreq_stall: got %b expected 0", o_stall_mem); end
    i_arst = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    i_dmem_rvalid = 1'b0; #1;
    checks++; if (o_load_data !== 64'd0) begin errors++; $display("FAIL stray_rvalid: got %h expected 0", o_load_data); end
    exp_load = 64'd0;
  endtask

  task automatic test_lb_lbu();
    logic [63:0] rd = 64'h0000_0000_8000_0000;
    run_access(1'b0, 3'b000, 64'h1003, 64'd0, rd, 0, 0, 0);
    checks++; if (ob_addr !== 64'h1000) begin errors++; $display("FAIL lb_addr: got %h expected %h", ob_addr, 64'h1000); end
    checks++; if (ob_load !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffffffffffff80", ob_load); end
    checks++; if (ob_stall !== 3) begin errors++; $display("FAIL lb_stall: got %0d expected 3", ob_stall); end
    run_access(1'b0, 3'b100, 64'h1003, 64'd0, rd, 0, 0, 0);
    checks++; if (ob_load !== 64'h80) begin errors++; $display("FAIL lbu_data: got %h expected 80", ob_load); end
    checks++; if (ob_stall !== 3) begin errors++; $display("FAIL lbu_stall: got %0d expected 3", ob_stall); end
    exp_load = 64'h80;
  endtask

  task automatic test_sh();
    run_access(1'b1, 3'b001, 64'h2006, 64'h1234, 64'd0, 0, 0, 0);
    checks++; if (ob_wdata !== 64'h1234_0000_0000_0000) begin errors++; $display("FAIL sh_wdata: got %h expected 1234000000000000", ob_wdata); end
    checks++; if (ob_wstrb !== 8'hC0) begin errors++; $display("FAIL sh_wstrb: got %h expected c0", ob_wstrb); end
    checks++; if (ob_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", ob_we); end
    checks++; if (ob_resp_seen !== 1'b0 || ob_stall !== 2) begin errors++; $display("FAIL sh_noresp: got resp=%0d stall=%0d expected 0/2", ob_resp_seen, ob_stall); end
    checks++; if (ob_load !== exp_load) begin errors++; $display("FAIL sh_keeps_load: got %h expected %h", ob_load, exp_load); end
  endtask

  task automatic test_ld_wait();
    logic [63:0] rd = {$urandom, $urandom};
    run_access(1'b0, 3'b011, 64'h3000, 64'd0, rd, 4, 3, 1);
    checks++; if (ob_stable !== 1'b1) begin errors++; $display("FAIL ld_stable: got %0d expected 1", ob_stable); end
    checks++; if (ob_stall !== 10 || ob_timeout) begin errors++; $display("FAIL ld_stall: got %0d expected 10", ob_stall); end
    checks++; if (ob_load !== rd) begin errors++; $display("FAIL ld_data: got %h expected %h", ob_load, rd); end
    exp_load = rd;
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 3'b010, 64'h4002, 64'd0, 64'd0, 0, 0, 0);
    checks++; if (ob_mis !== 1'b1 || ob_cause !== 4'd4) begin errors++; $display("FAIL lw_mis: got %b/%0d expected 1/4", ob_mis, ob_cause); end
    checks++; if (ob_stall !== 0 || ob_req_after !== 1'b0) begin errors++; $display("FAIL lw_noreq: got stall=%0d req=%b expected 0/0", ob_stall, ob_req_after); end
    run_access(1'b1, 3'b011, 64'h4004, 64'h55, 64'd0, 0, 0, 0);
    checks++; if (ob_mis !== 1'b1 || ob_cause !== 4'd6) begin errors++; $display("FAIL sd_mis: got %b/%0d expected 1/6", ob_mis, ob_cause); end
    checks++; if (ob_stall !== 0 || ob_req_after !== 1'b0) begin errors++; $display("FAIL sd_noreq: got stall=%0d req=%b expected 0/0", ob_stall, ob_req_after); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd;
    run_access(1'b1, 3'b010, 64'h5000, 64'hDEAD_BEEF, 64'd0, 0, 0, 0);
    checks++; if (ob_wstrb !== 8'h0F || ob_wdata !== 64'hDEAD_BEEF || ob_stall !== 2) begin errors++; $display("FAIL b2b_sw: got strb=%h wdata=%h stall=%0d expected 0f/deadbeef/2", ob_wstrb, ob_wdata, ob_stall); end
    rd = {$urandom, 32'hDEAD_BEEF};
    run_access(1'b0, 3'b110, 64'h5000, 64'd0, rd, 0, 0, 0);
    checks++; if (ob_stall !== 3) begin errors++; $display("FAIL b2b_lwu_stall: got %0d expected 3", ob_stall); end
    checks++; if (ob_load !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL b2b_lwu_data: got %h expected 00000000deadbeef", ob_load); end
    exp_load = 64'h0000_0000_DEAD_BEEF;
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [63:0] a, wd, rd;
    int          rdy, rv, n, exp_stall;
    bit          al;
    for (int k = 0; k < 60; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (we) f3[2] = 1'b0;
      n  = nbytes(f3);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'($urandom_range(0, 7) & ~(n - 1));
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      rdy = $urandom_range(0, 3);
      rv  = $urandom_range(0, 3);
      al  = is_aligned(a, f3);
      run_access(we, f3, a, wd, rd, rdy, rv, 1);
      if (!al) begin
        checks++; if (ob_mis !== 1'b1 || ob_cause !== (we ? 4'd6 : 4'd4) || ob_stall !== 0 || ob_req_after !== 1'b0)
          begin errors++; $display("FAIL rnd_mis[%0d]: got mis=%b cause=%0d stall=%0d req=%b expected 1/%0d/0/0", k, ob_mis, ob_cause, ob_stall, ob_req_after, we ? 6 : 4); end
      end else begin
        exp_stall = 1 + (rdy + 1) + (we ? 0 : rv + 1);
        if (!we) exp_load = m_load(a, f3, rd);
        checks++; if (ob_mis !== 1'b0 || ob_cause !== 4'd0) begin errors++; $display("FAIL rnd_exc[%0d]: got %b/%0d expected 0/0", k, ob_mis, ob_cause); end
        checks++; if (ob_stall !== exp_stall || ob_timeout) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", k, ob_stall, exp_stall); end
        checks++; if (ob_addr !== {a[63:3], 3'b000} || ob_we !== we || !ob_stable) begin errors++; $display("FAIL rnd_req[%0d]: got addr=%h we=%b stable=%0d expected %h/%b/1", k, ob_addr, ob_we, ob_stable, {a[63:3], 3'b000}, we); end
        checks++; if (ob_wstrb !== m_wstrb(a, f3) || ob_wdata !== m_wdata(a, wd)) begin errors++; $display("FAIL rnd_wlane[%0d]: got %h/%h expected %h/%h", k, ob_wstrb, ob_wdata, m_wstrb(a, f3), m_wdata(a, wd)); end
        checks++; if (ob_load !== exp_load) begin errors++; $display("FAIL rnd_load[%0d]: got %h expected %h", k, ob_load, exp_load); end
      end
    end
  endtask

  initial begin
    i_arst = 1'b1; i_mem_access = 1'b0; i_mem_we = 1'b0; i_func3 = 3'd0; i_addr = '0;
    i_write_data = '0; i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    exp_load = '0;
    test_reset();
    test_lb_lbu();
    test_sh();
    test_ld_wait();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
